cam_srl_ternary: RTL and testbench

Ternary content addressable memory built from shift-register lookup slices. It is the parametrised successor to the binary SRL CAM and adds three things:
- a per-bit compare mask (1 = compare, 0 = don't care) stored with each entry;
- per-entry valid bits, so deleted entries never match;
- a valid/ready write handshake, a clear-all command and a qualified match output.

It sits in lookup pipelines such as flow tables and ACL filters, where wildcard entries are needed.

---
 rtl/cam_pkg.sv | 21 ++
 rtl/priority_encoder.sv | 61 ++++++
 rtl/cam_srl_ternary.sv | 194 +++++++++++++++++++
 tb/tb_cam_srl_ternary.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the ternary SRL CAM: FSM encoding and sizing helpers.
package cam_pkg;

    typedef enum logic [1:0] {
        STATE_INIT   = 2'd0,
        STATE_IDLE   = 2'd1,
        STATE_WRITE  = 2'd2,
        STATE_DELETE = 2'd3
    } state_t;

    // Number of SRL slices needed to cover a data word.
    function automatic int slice_count(input int data_width, input int slice_width);
        return (data_width + slice_width - 32'd1) / slice_width;
    endfunction

    // Number of CAM entries for a given address width.
    function automatic int ram_depth(input int addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder: index and one-hot of the winning request bit.
module priority_encoder #(
    parameter int    WIDTH        = 8,
    parameter string LSB_PRIORITY = "HIGH",
    localparam int   IW           = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] request,
    output logic [WIDTH-1:0] one_hot,
    output logic [IW-1:0]    index,
    output logic             valid
);

    logic [IW-1:0]    index_s;
    logic             valid_s;
    logic [WIDTH-1:0] one_hot_s;

    if (LSB_PRIORITY == "HIGH") begin : g_lsb
        // Scan from the top so the lowest set bit is the last one written.
        always_comb begin
            index_s = '0;
            valid_s = 1'b0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (request[i]) begin
                    index_s = IW'(i);
                    valid_s = 1'b1;
                end else begin
                    index_s = index_s;
                end
            end
        end
    end else begin : g_msb
        // Scan from the bottom so the highest set bit is the last one written.
        always_comb begin
            index_s = '0;
            valid_s = 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                if (request[i]) begin
                    index_s = IW'(i);
                    valid_s = 1'b1;
                end else begin
                    index_s = index_s;
                end
            end
        end
    end

    // One-hot form of the winning index; all zero when nothing is requested.
    always_comb begin
        one_hot_s = '0;
        if (valid_s) begin
            one_hot_s[index_s] = 1'b1;
        end else begin
            one_hot_s = '0;
        end
    end

    assign one_hot = one_hot_s;
    assign index   = index_s;
    assign valid   = valid_s;

endmodule

// File: rtl/cam_srl_ternary.sv
// Ternary CAM built from shift-register lookup slices with per-entry valid bits,
// a valid/ready write port, clear-all and a one-cycle registered match path.
module cam_srl_ternary
    import cam_pkg::*;
#(
    parameter int  DATA_WIDTH  = 64,
    parameter int  ADDR_WIDTH  = 5,
    parameter int  SLICE_WIDTH = 4,
    localparam int RAM_DEPTH   = ram_depth(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] write_mask,
    input  logic                  write_delete,
    input  logic                  write_valid,
    output logic                  write_ready,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] compare_data,
    input  logic                  compare_valid,
    output logic [RAM_DEPTH-1:0]  match_many,
    output logic [RAM_DEPTH-1:0]  match_single,
    output logic [ADDR_WIDTH-1:0] match_addr,
    output logic                  match,
    output logic                  match_valid,
    output logic [RAM_DEPTH-1:0]  entry_valid
);

    localparam int SLICE_COUNT = slice_count(DATA_WIDTH, SLICE_WIDTH);
    localparam int PAD_WIDTH   = SLICE_COUNT * SLICE_WIDTH;
    localparam int SRL_DEPTH   = 2 ** SLICE_WIDTH;

    state_t                 state_q, state_d;
    logic [SLICE_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [PAD_WIDTH-1:0]   data_q, data_d;
    logic [PAD_WIDTH-1:0]   mask_q, mask_d;
    logic [RAM_DEPTH-1:0]   entry_valid_q, entry_valid_d;
    logic                   write_ready_q, write_ready_d;
    logic [RAM_DEPTH-1:0]   match_many_q, match_many_d;
    logic                   match_valid_q, match_valid_d;

    logic [RAM_DEPTH-1:0]   shift_en_s;
    logic [SLICE_COUNT-1:0] shift_bit_s;
    logic [RAM_DEPTH-1:0]   row_hit_s;
    logic [PAD_WIDTH-1:0]   cmp_pad_s;

    // Padding bits above DATA_WIDTH compare as zero against a zero mask.
    assign cmp_pad_s = PAD_WIDTH'(compare_data);

    // Sequencer: init sweep, idle handshake, row rewrite and row delete.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        addr_d        = addr_q;
        data_d        = data_q;
        mask_d        = mask_q;
        entry_valid_d = entry_valid_q;
        shift_en_s    = '0;
        case (state_q)
            STATE_INIT: begin
                shift_en_s    = '1;
                entry_valid_d = '0;
                if (count_q == '0) begin
                    state_d = STATE_IDLE;
                end else begin
                    count_d = count_q - SLICE_WIDTH'(1);
                end
            end
            STATE_IDLE: begin
                if (clear) begin
                    state_d       = STATE_INIT;
                    count_d       = '1;
                    entry_valid_d = '0;
                end else if (write_valid && write_ready_q) begin
                    addr_d  = write_addr;
                    data_d  = PAD_WIDTH'(write_data);
                    mask_d  = PAD_WIDTH'(write_mask);
                    count_d = '1;
                    if (write_delete) begin
                        state_d                   = STATE_DELETE;
                        entry_valid_d[write_addr] = 1'b0;
                    end else begin
                        state_d = STATE_WRITE;
                    end
                end else begin
                    state_d = STATE_IDLE;
                end
            end
            STATE_WRITE: begin
                shift_en_s[addr_q] = 1'b1;
                if (count_q == '0) begin
                    entry_valid_d[addr_q] = 1'b1;
                    state_d               = STATE_IDLE;
                end else begin
                    count_d = count_q - SLICE_WIDTH'(1);
                end
            end
            STATE_DELETE: begin
                shift_en_s[addr_q] = 1'b1;
                if (count_q == '0) begin
                    state_d = STATE_IDLE;
                end else begin
                    count_d = count_q - SLICE_WIDTH'(1);
                end
            end
            default: begin
                state_d = STATE_INIT;
                count_d = '1;
            end
        endcase
        write_ready_d = (state_d == STATE_IDLE);
        match_many_d  = entry_valid_q & ~shift_en_s & row_hit_s;
        match_valid_d = compare_valid;
    end

    // Control and match registers; rst restarts the zeroing sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= STATE_INIT;
            count_q       <= '1;
            addr_q        <= '0;
            data_q        <= '0;
            mask_q        <= '0;
            entry_valid_q <= '0;
            write_ready_q <= 1'b0;
            match_many_q  <= '0;
            match_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            mask_q        <= mask_d;
            entry_valid_q <= entry_valid_d;
            write_ready_q <= write_ready_d;
            match_many_q  <= match_many_d;
            match_valid_q <= match_valid_d;
        end
    end

    for (genvar s = 0; s < SLICE_COUNT; s++) begin : g_shift_bit
        // Bit stored at lookup position count: does that slice value match the entry?
        always_comb begin
            if (state_q == STATE_WRITE) begin
                shift_bit_s[s] = (((count_q ^ data_q[s*SLICE_WIDTH +: SLICE_WIDTH])
                                   & mask_q[s*SLICE_WIDTH +: SLICE_WIDTH]) == '0);
            end else begin
                shift_bit_s[s] = 1'b0;
            end
        end
    end

    for (genvar r = 0; r < RAM_DEPTH; r++) begin : g_row
        logic [SLICE_COUNT-1:0] slice_hit_s;
        for (genvar s = 0; s < SLICE_COUNT; s++) begin : g_slice
            logic [SRL_DEPTH-1:0] srl_q, srl_d;

            // Shift one bit in while the row is being (re)loaded.
            always_comb begin
                if (shift_en_s[r]) begin
                    srl_d = {srl_q[SRL_DEPTH-2:0], shift_bit_s[s]};
                end else begin
                    srl_d = srl_q;
                end
            end

            // SRL storage has no reset; the init sweep zeroes it.
            always_ff @(posedge clk) begin
                srl_q <= srl_d;
            end

            assign slice_hit_s[s] = srl_q[cmp_pad_s[s*SLICE_WIDTH +: SLICE_WIDTH]];
        end
        assign row_hit_s[r] = &slice_hit_s;
    end

    priority_encoder #(
        .WIDTH       (RAM_DEPTH),
        .LSB_PRIORITY("HIGH")
    ) u_prio (
        .request(match_many_q),
        .one_hot(match_single),
        .index  (match_addr),
        .valid  (match)
    );

    assign write_ready = write_ready_q;
    assign match_many  = match_many_q;
    assign match_valid = match_valid_q;
    assign entry_valid = entry_valid_q;

endmodule

// File: tb/tb_cam_srl_ternary.sv
// Scoreboard bench for cam_srl_ternary with DATA_WIDTH=8, ADDR_WIDTH=3, SLICE_WIDTH=4.
module tb_cam_srl_ternary;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] write_addr;
    logic [7:0] write_data;
    logic [7:0] write_mask;
    logic       write_delete;
    logic       write_valid;
    logic       write_ready;
    logic       clear;
    logic [7:0] compare_data;
    logic       compare_valid;
    logic [7:0] match_many;
    logic [7:0] match_single;
    logic [2:0] match_addr;
    logic       match;
    logic       match_valid;
    logic [7:0] entry_valid;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;

    typedef struct {
        logic [7:0] key;
        logic [7:0] many;
        int         cyc;
    } exp_t;
    exp_t sb_q[$];

    cam_srl_ternary #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3),
        .SLICE_WIDTH(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_mask   (write_mask),
        .write_delete (write_delete),
        .write_valid  (write_valid),
        .write_ready  (write_ready),
        .clear        (clear),
        .compare_data (compare_data),
        .compare_valid(compare_valid),
        .match_many   (match_many),
        .match_single (match_single),
        .match_addr   (match_addr),
        .match        (match),
        .match_valid  (match_valid),
        .entry_valid  (entry_valid)
    );

    always #5 clk = ~clk;

    // Cycle stamp used to check the one-cycle match latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lowest_onehot(input logic [7:0] m);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 7; i >= 0; i--) if (m[i]) r = 8'h01 << i;
        return r;
    endfunction

    function automatic logic [2:0] lowest_index(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
        return r;
    endfunction

    // Monitor: every qualified match result is popped and checked.
    always @(negedge clk) begin
        if (match_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL unexpected_match_valid: got match_many %0h with no pending key", match_many);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check($sformatf("match_many key=%0h", e.key), match_many, e.many);
                check($sformatf("match_single key=%0h", e.key), match_single, lowest_onehot(e.many));
                check($sformatf("match_addr key=%0h", e.key), match_addr, lowest_index(e.many));
                check($sformatf("match key=%0h", e.key), match, |e.many);
                check($sformatf("latency key=%0h", e.key), cyc - e.cyc, 1);
            end
        end
    end

    // Present a key for the coming edge and record its expected result.
    task automatic issue(input logic [7:0] key, input logic [7:0] exp_many);
        exp_t e;
        compare_data  = key;
        compare_valid = 1'b1;
        e.key  = key;
        e.many = exp_many;
        e.cyc  = cyc;
        sb_q.push_back(e);
    endtask

    task automatic lookup(input logic [7:0] key, input logic [7:0] exp_many);
        issue(key, exp_many);
        @(negedge clk);
        compare_valid = 1'b0;
        @(negedge clk);
    endtask

    // Count negedge samples with write_ready low, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (write_ready !== 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d, input logic [7:0] m,
                            input logic del);
        int t;
        t = 0;
        while (write_ready !== 1'b1 && t < 64) begin
            t++;
            @(negedge clk);
        end
        check("write_ready_before_request", write_ready, 1'b1);
        write_addr   = a;
        write_data   = d;
        write_mask   = m;
        write_delete = del;
        write_valid  = 1'b1;
        @(negedge clk);
        write_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        rst           = 1'b1;
        write_addr    = 3'd0;
        write_data    = 8'h00;
        write_mask    = 8'h00;
        write_delete  = 1'b0;
        write_valid   = 1'b0;
        clear         = 1'b0;
        compare_data  = 8'h00;
        compare_valid = 1'b0;
        repeat (3) @(negedge clk);

        // 1. Reset values, then ready timing counted from the last edge that sampled rst.
        check("rst_write_ready", write_ready, 1'b0);
        check("rst_match_valid", match_valid, 1'b0);
        check("rst_match_many", match_many, 8'h00);
        check("rst_entry_valid", entry_valid, 8'h00);
        rst = 1'b0;
        wait_ready(n);
        check("ready_edges_after_rst", n + 1, 17);
        check("init_entry_valid", entry_valid, 8'h00);
        lookup(8'h00, 8'h00);

        // 2. Exact entry.
        do_write(3'd2, 8'hA5, 8'hFF, 1'b0);
        wait_ready(n);
        check("write_ready_low_cycles", n, 16);
        check("entry_valid_after_write2", entry_valid, 8'h04);
        lookup(8'hA5, 8'h04);
        lookup(8'hA4, 8'h00);

        // 3. Wildcard entries and priority.
        do_write(3'd5, 8'h30, 8'hF0, 1'b0);
        do_write(3'd6, 8'h00, 8'h00, 1'b0);
        wait_ready(n);
        check("entry_valid_after_wild", entry_valid, 8'h64);
        lookup(8'h3C, 8'h60);
        lookup(8'h4C, 8'h40);
        lookup(8'hA5, 8'h44);

        // 4. Delete: valid bit drops on the acceptance edge.
        do_write(3'd5, 8'h00, 8'h00, 1'b1);
        check("entry_valid_delete_edge", entry_valid, 8'h44);
        wait_ready(n);
        lookup(8'h3C, 8'h40);

        // 5. Search continuously while entry 1 is being written.
        do_write(3'd1, 8'h11, 8'hFF, 1'b0);
        k = 0;
        while (write_ready !== 1'b1 && k < 40) begin
            issue(k[0] ? 8'h11 : 8'h3C, 8'h40);
            k++;
            @(negedge clk);
        end
        compare_valid = 1'b0;
        check("search_write_cycles", k, 16);
        @(negedge clk);
        check("entry_valid_after_write1", entry_valid, 8'h46);
        lookup(8'h11, 8'h42);
        lookup(8'h3C, 8'h40);

        // 6a. Clear in idle.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_entry_valid_edge", entry_valid, 8'h00);
        wait_ready(n);
        check("clear_init_cycles", n, 16);
        check("clear_entry_valid_done", entry_valid, 8'h00);
        lookup(8'h3C, 8'h00);
        lookup(8'hA5, 8'h00);

        // 6b. Reset during the eighth write cycle.
        do_write(3'd3, 8'h77, 8'hFF, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_midwrite_ready", write_ready, 1'b0);
        check("rst_midwrite_entry_valid", entry_valid, 8'h00);
        wait_ready(n);
        check("rst_midwrite_init_cycles", n, 16);
        check("rst_midwrite_entry3", entry_valid, 8'h00);
        lookup(8'h77, 8'h00);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
